// File: rtl/sipo_rx_8bit.sv
// ---------------------------------------------------------------------------
// sipo_rx_8bit
//   Serial-to-parallel receiver. A frame begins with a one-cycle frame_start
//   pulse, which also latches the bit order (msb_first). WIDTH data bits then
//   arrive on ser_in, qualified by ser_valid and possibly gapped. The finished
//   word is offered on a valid/ready holding register.
//
//   Optional feature macro: SER_RX_PARITY_EN
//     defined   : each frame carries one extra even-parity bit after the data;
//                 a mismatch pulses parity_err and drops the word.
//     undefined : frames are WIDTH data bits only; parity_err is tied to 0.
//
//   Output handshake: out_data is valid while out_valid=1 and is held stable
//   until the consumer raises out_ready. A transfer happens on a rising edge
//   where out_valid & out_ready. out_valid drops on the following cycle unless
//   a new word is loaded on that same edge. A word that completes while the
//   register is full and not being drained is dropped and overrun pulses.
//
//   Status pulses (overrun, frame_err, parity_err) are registered and last
//   exactly one cycle.
// ---------------------------------------------------------------------------
module sipo_rx_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             msb_first,
    input  logic             ser_valid,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    // Receiver FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SER_RX_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    // Count value held just before the last data bit is taken.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [WIDTH-1:0] sr_q,         sr_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic             msb_q,        msb_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic             out_valid_q,  out_valid_d;
    logic             overrun_q,    overrun_d;
    logic             frame_err_q,  frame_err_d;

    // Internal events produced by the FSM for the delivery logic.
    logic             done;        // a complete, good word is available
    logic [WIDTH-1:0] word;        // the word to deliver when done=1
    logic [WIDTH-1:0] shifted;     // shift register after taking ser_in
    logic             can_load;    // holding register can accept a word

`ifdef SER_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
    logic             par_fail;
`endif

    // Shift register with the incoming bit applied in the latched order.
    always_comb begin
        shifted = sr_q;
        if (msb_q) begin
            shifted = {sr_q[WIDTH-2:0], ser_in};
        end else begin
            shifted = {ser_in, sr_q[WIDTH-1:1]};
        end
    end

    // Receiver FSM: frame framing, bit collection and parity check.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        msb_d       = msb_q;
        frame_err_d = 1'b0;
        done        = 1'b0;
        word        = sr_q;
`ifdef SER_RX_PARITY_EN
        par_fail    = 1'b0;
`endif

        if (frame_start) begin
            // A new frame always wins; any coincident ser_valid is ignored.
            // Restarting over a frame in progress discards the partial word.
            if (state_q != ST_IDLE) begin
                frame_err_d = 1'b1;
            end
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sr_d    = '0;
            msb_d   = msb_first;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (ser_valid) begin
                        sr_d  = shifted;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
`ifdef SER_RX_PARITY_EN
                            state_d = ST_PAR;
`else
                            state_d = ST_IDLE;
                            done    = 1'b1;
                            word    = shifted;
`endif
                        end
                    end
                end
`ifdef SER_RX_PARITY_EN
                ST_PAR: begin
                    if (ser_valid) begin
                        state_d = ST_IDLE;
                        // Even parity: data bits plus parity bit XOR to zero.
                        if ((^sr_q ^ ser_in) == 1'b0) begin
                            done = 1'b1;
                            word = sr_q;
                        end else begin
                            par_fail = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // IDLE (and any unreachable encoding) waits for frame_start;
                    // stray serial bits are ignored here.
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: load a completed word or flag an overrun.
    always_comb begin
        can_load    = !out_valid_q || out_ready;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (done) begin
            if (can_load) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

`ifdef SER_RX_PARITY_EN
    // Parity error pulse follows the parity check by one register stage.
    always_comb begin
        parity_err_d = par_fail;
    end
`endif

    // Register update for FSM, shift path, holding register and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            msb_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            msb_q       <= msb_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SER_RX_PARITY_EN
    // Parity error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx_8bit.sv
// ---------------------------------------------------------------------------
// tb_sipo_rx_8bit
//   Bench for sipo_rx_8bit (WIDTH=8). Build with +define+SER_RX_PARITY_EN to
//   exercise the parity frame format as well.
// ---------------------------------------------------------------------------
module tb_sipo_rx_8bit;

    localparam int W = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_start;
    logic         msb_first;
    logic         ser_valid;
    logic         ser_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         frame_err;
    logic         parity_err;

    always #5 clk = ~clk;

    sipo_rx_8bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .msb_first   (msb_first),
        .ser_valid   (ser_valid),
        .ser_in      (ser_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           ovr_cnt = 0;
    int           ferr_cnt = 0;
    int           perr_cnt = 0;

    typedef struct {
        logic         msb;      // bit order for the frame
        logic [W-1:0] stream;   // bits in time order, stream[W-1] sent first
        logic         gap;      // insert an idle cycle after every bit
        logic [W-1:0] expect_w; // word the receiver must assemble
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sampled on the falling edge: counts pulses and pops the scoreboard on
    // every accepted transfer.
    task automatic monitor();
        logic [W-1:0] e;
        if (rst_n) begin
            if (overrun)    ovr_cnt++;
            if (frame_err)  ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", {24'd0, out_data}, {24'd0, e});
                end
            end
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic start_frame(input logic m);
        frame_start = 1'b1;
        msb_first   = m;
        ser_valid   = 1'b0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic gap);
        ser_valid = 1'b1;
        ser_in    = b;
        step();
        ser_valid = 1'b0;
        if (gap) step();
    endtask

    // Full frame; flip inverts the parity bit when parity is built in.
    task automatic send_stream(input logic m, input logic [W-1:0] s, input logic gap,
                               input logic flip);
        start_frame(m);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(s[i], (i != 0) ? gap : 1'b0);
        end
`ifdef SER_RX_PARITY_EN
        send_bit((^s) ^ flip, 1'b0);
`else
        if (flip) begin
            // no parity bit in this frame format
        end
`endif
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int ovr0;
        int ferr0;
        logic [W-1:0] s;
        logic         m;

        rst_n = 1'b0; frame_start = 1'b0; msb_first = 1'b0;
        ser_valid = 1'b0; ser_in = 1'b0; out_ready = 1'b1;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 8'hA5, 1'b1, 8'hA5};
        vecs[2] = '{1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 8'hC1, 1'b0, 8'h83};
        vecs[4] = '{1'b0, 8'h01, 1'b1, 8'h80};
        vecs[5] = '{1'b1, 8'hFF, 1'b0, 8'hFF};
        vecs[6] = '{1'b0, 8'h12, 1'b0, 8'h48};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   {31'd0, out_valid},  32'd0);
        check("rst_data",    {24'd0, out_data},   32'd0);
        check("rst_pulses",  {29'd0, overrun, frame_err, parity_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Serial bits with no frame_start must be ignored
        for (int i = 0; i < W; i++) send_bit(1'b1, 1'b0);
        step();
        check("idle_ignore_valid", {31'd0, out_valid}, 32'd0);
        check("idle_ignore_ferr",  ferr_cnt, 0);

        // Table-driven frames with a free-running consumer
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(vecs[k].expect_w);
            send_stream(vecs[k].msb, vecs[k].stream, vecs[k].gap, 1'b0);
            check($sformatf("latency_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec_data_%0d", k), {24'd0, out_data}, {24'd0, vecs[k].expect_w});
            step();
        end

        // Randomised frames checked only through the scoreboard
        for (int k = 0; k < 6; k++) begin
            s = 8'($urandom_range(0, 255));
            m = 1'($urandom_range(0, 1));
            exp_q.push_back(m ? s : rev(s));
            send_stream(m, s, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(1, 3)) step();
        end

        // Overrun: consumer stalled across two completed words
        out_ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_stream(1'b1, 8'h3C, 1'b0, 1'b0);
        check("ovr_first_valid", {31'd0, out_valid}, 32'd1);
        send_stream(1'b1, 8'hC3, 1'b0, 1'b0);
        check("ovr_pulse_now",   {31'd0, overrun},   32'd1);
        step();
        check("ovr_pulse_once",  ovr_cnt - ovr0,     1);
        check("ovr_data_held",   {24'd0, out_data},  32'h3C);
        check("ovr_valid_held",  {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        check("ovr_drain_valid", {31'd0, out_valid}, 32'd0);

        // Abort: frame restarted after 5 bits
        ferr0 = ferr_cnt;
        start_frame(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        exp_q.push_back(8'h0F);
        send_stream(1'b1, 8'h0F, 1'b0, 1'b0);
        check("abort_data",  {24'd0, out_data}, 32'h0F);
        step();
        check("abort_ferr_once", ferr_cnt - ferr0, 1);

`ifdef SER_RX_PARITY_EN
        // Parity good then bad
        exp_q.push_back(8'h81);
        send_stream(1'b1, 8'h81, 1'b0, 1'b0);
        check("par_good_valid", {31'd0, out_valid}, 32'd1);
        step();
        send_stream(1'b1, 8'h81, 1'b0, 1'b1);
        check("par_bad_pulse", {31'd0, parity_err}, 32'd1);
        check("par_bad_valid", {31'd0, out_valid},  32'd0);
        step();
        check("par_err_count", perr_cnt, 1);
`else
        check("parity_tied_low", perr_cnt, 0);
`endif

        // Asynchronous reset mid-frame with a word held in the register
        out_ready = 1'b0;
        send_stream(1'b1, 8'hA5, 1'b0, 1'b0);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        start_frame(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",  {31'd0, out_valid}, 32'd0);
        check("async_rst_data",   {24'd0, out_data},  32'd0);
        check("async_rst_pulses", {29'd0, overrun, frame_err, parity_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < W; i++) send_bit(1'b1, 1'b0);
        step();
        check("post_rst_ignore", {31'd0, out_valid}, 32'd0);

        // Receiver recovers normally afterwards
        exp_q.push_back(8'h5A);
        send_stream(1'b0, 8'h5A, 1'b1, 1'b0);
        step();
        step();

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
